// File: rtl/alu.sv
// alu: 32-bit registered arithmetic/logic unit for the execute stage and branch/compare logic.
// Ports:
//   clk      - system clock, all updates on the rising edge
//   rst      - synchronous active-high reset
//   a, b     - 32-bit operands; only b[4:0] is used as the shift amount
//   op       - operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT
//   result   - registered operation result
//   zero     - registered, set when the result is 0 (held at 0 during reset)
//   negative - registered copy of result[31]
//   carry    - registered ADD carry-out / SUB borrow, 0 for other ops
//   overflow - registered signed overflow for ADD/SUB, 0 for other ops
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  op,
   output logic [31:0] result,
   output logic        zero,
   output logic        negative,
   output logic        carry,
   output logic        overflow
);

   localparam int unsigned W     = 32;
   localparam int unsigned SH_W  = 5;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRL = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;

   logic [W-1:0]    result_d, result_q;
   logic            zero_d, zero_q;
   logic            negative_d, negative_q;
   logic            carry_d, carry_q;
   logic            overflow_d, overflow_q;

   logic [W:0]      sum;
   logic [W:0]      diff;
   logic [SH_W-1:0] shamt;
   logic            slt;

   // Next-state datapath; reset forces every output to 0 and discards the op.
   always_comb begin
      result_d   = '0;
      zero_d     = 1'b0;
      negative_d = 1'b0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;

      sum   = (W+1)'(a) + (W+1)'(b);
      // Bit W of the widened difference is the unsigned borrow.
      diff  = (W+1)'(a) - (W+1)'(b);
      shamt = b[SH_W-1:0];
      // Full signed compare, correct at the extremes unlike the wrapped diff sign.
      slt   = $signed(a) < $signed(b);

      unique case (op)
         OP_ADD: begin
            result_d   = sum[W-1:0];
            carry_d    = sum[W];
            overflow_d = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
         end
         OP_SUB: begin
            result_d   = diff[W-1:0];
            carry_d    = diff[W];
            overflow_d = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
         end
         OP_AND:  result_d = a & b;
         OP_OR:   result_d = a | b;
         OP_XOR:  result_d = a ^ b;
         OP_SLL:  result_d = a << shamt;
         OP_SRL:  result_d = a >> shamt;
         OP_SLT:  result_d = W'(slt);
         default: result_d = '0;
      endcase

      zero_d     = (result_d == '0);
      negative_d = result_d[W-1];

      if (rst) begin
         result_d   = '0;
         zero_d     = 1'b0;
         negative_d = 1'b0;
         carry_d    = 1'b0;
         overflow_d = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign negative = negative_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu.
module tb_alu;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic [31:0] result;
   logic        zero;
   logic        negative;
   logic        carry;
   logic        overflow;

   int total;
   int bad;

   alu dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .op       (op),
      .result   (result),
      .zero     (zero),
      .negative (negative),
      .carry    (carry),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Drive one vector, clock it in, and check result and all flags after the edge.
   task automatic run(input string tag, input logic r, input logic [31:0] va,
                      input logic [31:0] vb, input logic [2:0] vop,
                      input logic [31:0] er, input logic ez, input logic en,
                      input logic ec, input logic ev);
      rst = r;
      a   = va;
      b   = vb;
      op  = vop;
      @(posedge clk);
      #1;
      check({tag, ".result"},   result,          er);
      check({tag, ".zero"},     32'(zero),       32'(ez));
      check({tag, ".negative"}, 32'(negative),   32'(en));
      check({tag, ".carry"},    32'(carry),      32'(ec));
      check({tag, ".overflow"}, 32'(overflow),   32'(ev));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; a = '0; b = '0; op = '0;
      @(negedge clk);

      // Reset held for two cycles with an ADD on the inputs.
      run("rst0", 1'b1, 32'd10, 32'd5, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run("rst1", 1'b1, 32'd10, 32'd5, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run("rel",  1'b0, 32'd10, 32'd5, 3'd0, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);

      // ADD/SUB basics
      run("sub",   1'b0, 32'd10, 32'd5, 3'd1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      run("subz",  1'b0, 32'd5,  32'd5, 3'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Overflow and borrow
      run("addov", 1'b0, 32'h7FFFFFFF, 32'd1, 3'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
      run("addc",  1'b0, 32'hFFFFFFFF, 32'd1, 3'd0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
      run("subb",  1'b0, 32'd5, 32'd10,       3'd1, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b1, 1'b0);
      run("subov", 1'b0, 32'h80000000, 32'd1, 3'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // Logic ops
      run("and", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd2, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0);
      run("or",  1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd3, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0, 1'b0);
      run("xor", 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 32'hFF00FF00, 1'b0, 1'b1, 1'b0, 1'b0);

      // Shifts
      run("sll4",  1'b0, 32'h80000001, 32'd4,  3'd5, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0);
      run("srl4",  1'b0, 32'h80000001, 32'd4,  3'd6, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
      run("sll33", 1'b0, 32'h80000001, 32'd33, 3'd5, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0);
      run("sll0",  1'b0, 32'h80000001, 32'd0,  3'd5, 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0);
      run("srl0",  1'b0, 32'h80000001, 32'd0,  3'd6, 32'h80000001, 1'b0, 1'b1, 1'b0, 1'b0);
      run("srl31", 1'b0, 32'h80000001, 32'd31, 3'd6, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);

      // SLT at signed extremes
      run("slt0", 1'b0, 32'hFFFFFFFF, 32'd1,        3'd7, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      run("slt1", 1'b0, 32'd1,        32'hFFFFFFFF, 3'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      run("slt2", 1'b0, 32'h80000000, 32'h7FFFFFFF, 3'd7, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      run("slt3", 1'b0, 32'h7FFFFFFF, 32'h80000000, 3'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Mid-stream single-cycle reset: that op is discarded, later ops resume.
      run("ms0", 1'b0, 32'd7,        32'd3, 3'd0, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      run("ms1", 1'b1, 32'hFFFFFFFF, 32'd1, 3'd0, 32'd0,  1'b0, 1'b0, 1'b0, 1'b0);
      run("ms2", 1'b0, 32'd3,        32'd7, 3'd1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0);
      run("ms3", 1'b0, 32'h0000FFFF, 32'd8, 3'd5, 32'h00FFFF00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
